// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- parametrised register file with a per-register busy scoreboard.
//
// Two combinational read ports, one synchronous write port, an optional
// same-cycle write-to-read bypass and an optional hardwired-zero register 0.
// Decode sets a register's busy flag with MARK when it issues a producer;
// writeback clears it with the WE3 write that delivers the result.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   BYPASS   1 = a same-cycle write is forwarded to a matching read port
//   ZERO_REG 1 = register 0 reads 0, ignores writes and is never busy
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high; drops same-cycle WE3 / MARK
//   A1, A2         read addresses
//   RD1, RD2       read data (combinational)
//   BUSY1, BUSY2   register at A1 / A2 has a pending producer
//   WE3, A3, WD3   write enable, address, data
//   MARK, MA       set the busy flag of register MA
//   ANY_BUSY       OR of all registered busy flags (bypass does not affect it)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              MARK,
    input  logic [ADDR_W-1:0] MA,
    output logic              ANY_BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    // Writes and marks aimed at a hardwired-zero register 0 are discarded.
    wire w_zero_en  = (ZERO_REG != 0);
    wire w_we_ok    = WE3  && !(w_zero_en && (A3 == '0));
    wire w_mark_ok  = MARK && !(w_zero_en && (MA == '0));
    wire w_bypass_en = (BYPASS != 0);

    // NOTE: the array is reset entry by entry because every register must read
    // 0 after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; when WE3 and MARK hit
            // the same address the later MARK assignment wins, so the new
            // producer leaves the register busy.
            if (w_we_ok) begin
                r_regs[A3] <= WD3;
                r_busy[A3] <= 1'b0;
            end
            if (w_mark_ok) begin
                r_busy[MA] <= 1'b1;
            end
        end
    end

    // Read port 1. Bypass reports not-busy: the flag reflects the state after
    // the write, even if MARK targets the same register this cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latches).
        RD1   = r_regs[A1];
        BUSY1 = r_busy[A1];
        if (w_zero_en && (A1 == '0)) begin
            RD1   = '0;
            BUSY1 = 1'b0;
        end else if (w_bypass_en && WE3 && (A3 == A1)) begin
            RD1   = WD3;
            BUSY1 = 1'b0;
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        RD2   = r_regs[A2];
        BUSY2 = r_busy[A2];
        if (w_zero_en && (A2 == '0)) begin
            RD2   = '0;
            BUSY2 = 1'b0;
        end else if (w_bypass_en && WE3 && (A3 == A2)) begin
            RD2   = WD3;
            BUSY2 = 1'b0;
        end
    end

    assign ANY_BUSY = |r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb.
//
// Four instances: u0 (BYPASS=1), u1 (BYPASS=0), u2 (ZERO_REG=1) at 8x8, and
// u3 at DATA_W=16 / ADDR_W=4. Stimulus drives inputs just after a rising edge
// and queues the hand-computed expected outputs; a monitor drains the queue on
// every falling edge and compares against the selected instance.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    typedef enum logic [2:0] {K_RD1, K_RD2, K_B1, K_B2, K_ANY} kind_e;

    typedef struct {
        int          dut;
        kind_e       kind;
        logic [15:0] value;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8 instances u0..u2
    logic       rst_a  [3];
    logic [2:0] a1_a   [3];
    logic [2:0] a2_a   [3];
    logic [7:0] rd1_a  [3];
    logic [7:0] rd2_a  [3];
    logic       b1_a   [3];
    logic       b2_a   [3];
    logic       we_a   [3];
    logic [2:0] a3_a   [3];
    logic [7:0] wd_a   [3];
    logic       mk_a   [3];
    logic [2:0] ma_a   [3];
    logic       any_a  [3];

    // 16x16 instance u3
    logic        rst_w, b1_w, b2_w, we_w, mk_w, any_w;
    logic [3:0]  a1_w, a2_w, a3_w, ma_w;
    logic [15:0] rd1_w, rd2_w, wd_w;

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk(clk), .reset(rst_a[0]), .A1(a1_a[0]), .A2(a2_a[0]),
        .RD1(rd1_a[0]), .RD2(rd2_a[0]), .BUSY1(b1_a[0]), .BUSY2(b2_a[0]),
        .WE3(we_a[0]), .A3(a3_a[0]), .WD3(wd_a[0]), .MARK(mk_a[0]),
        .MA(ma_a[0]), .ANY_BUSY(any_a[0]));

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u1 (
        .clk(clk), .reset(rst_a[1]), .A1(a1_a[1]), .A2(a2_a[1]),
        .RD1(rd1_a[1]), .RD2(rd2_a[1]), .BUSY1(b1_a[1]), .BUSY2(b2_a[1]),
        .WE3(we_a[1]), .A3(a3_a[1]), .WD3(wd_a[1]), .MARK(mk_a[1]),
        .MA(ma_a[1]), .ANY_BUSY(any_a[1]));

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u2 (
        .clk(clk), .reset(rst_a[2]), .A1(a1_a[2]), .A2(a2_a[2]),
        .RD1(rd1_a[2]), .RD2(rd2_a[2]), .BUSY1(b1_a[2]), .BUSY2(b2_a[2]),
        .WE3(we_a[2]), .A3(a3_a[2]), .WD3(wd_a[2]), .MARK(mk_a[2]),
        .MA(ma_a[2]), .ANY_BUSY(any_a[2]));

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) u3 (
        .clk(clk), .reset(rst_w), .A1(a1_w), .A2(a2_w),
        .RD1(rd1_w), .RD2(rd2_w), .BUSY1(b1_w), .BUSY2(b2_w),
        .WE3(we_w), .A3(a3_w), .WD3(wd_w), .MARK(mk_w),
        .MA(ma_w), .ANY_BUSY(any_w));

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // ---------------------------------------------------------------- monitor
    function automatic logic [15:0] actual(int d, kind_e k);
        if (d == 3) begin
            case (k)
                K_RD1:   return rd1_w;
                K_RD2:   return rd2_w;
                K_B1:    return {15'd0, b1_w};
                K_B2:    return {15'd0, b2_w};
                default: return {15'd0, any_w};
            endcase
        end
        case (k)
            K_RD1:   return {8'd0, rd1_a[d]};
            K_RD2:   return {8'd0, rd2_a[d]};
            K_B1:    return {15'd0, b1_a[d]};
            K_B2:    return {15'd0, b2_a[d]};
            default: return {15'd0, any_a[d]};
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [15:0] got;
        got = actual(e.dut, e.kind);
        n_vec++;
        if (got !== e.value) begin
            n_fail++;
            $display("FAIL %s (u%0d): got 0x%04h, expected 0x%04h",
                     e.name, e.dut, got, e.value);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            check(exp_q.pop_front());
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic expect_out(input int d, input kind_e k, input logic [15:0] v,
                              input string nm);
        exp_t e;
        e.dut = d; e.kind = k; e.value = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle_all(input logic rst);
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = rst; a1_a[i] = '0; a2_a[i] = '0; we_a[i] = 1'b0;
            a3_a[i] = '0; wd_a[i] = '0; mk_a[i] = 1'b0; ma_a[i] = '0;
        end
        rst_w = rst; a1_w = '0; a2_w = '0; we_w = 1'b0; a3_w = '0;
        wd_w = '0; mk_w = 1'b0; ma_w = '0;
    endtask

    // Advance to just after the next rising edge, then drive one 8x8 instance.
    task automatic drive8(input int d, input logic rst, input logic we,
                          input logic [2:0] a3, input logic [7:0] wd,
                          input logic mk, input logic [2:0] ma,
                          input logic [2:0] a1, input logic [2:0] a2);
        @(posedge clk); #1;
        idle_all(1'b0);
        rst_a[d] = rst; we_a[d] = we; a3_a[d] = a3; wd_a[d] = wd;
        mk_a[d] = mk; ma_a[d] = ma; a1_a[d] = a1; a2_a[d] = a2;
    endtask

    task automatic drive16(input logic we, input logic [3:0] a3,
                           input logic [15:0] wd, input logic [3:0] a1,
                           input logic [3:0] a2);
        @(posedge clk); #1;
        idle_all(1'b0);
        we_w = we; a3_w = a3; wd_w = wd; a1_w = a1; a2_w = a2;
    endtask

    initial begin
        idle_all(1'b1);
        @(posedge clk); #1;
        idle_all(1'b0);

        // Reset state: sweep both ports across all addresses on u0.
        for (int i = 0; i < 8; i++) begin
            drive8(0, 0, 0, 0, 8'h00, 0, 0, 3'(i), 3'(7 - i));
            expect_out(0, K_RD1, 16'h0, "reset_rd1");
            expect_out(0, K_RD2, 16'h0, "reset_rd2");
            expect_out(0, K_B1,  16'h0, "reset_busy1");
            expect_out(0, K_B2,  16'h0, "reset_busy2");
            expect_out(0, K_ANY, 16'h0, "reset_any");
        end

        // Write with bypass: visible in the write cycle and after.
        drive8(0, 0, 1, 5, 8'h39, 0, 0, 5, 0);
        expect_out(0, K_RD1, 16'h39, "bypass_same_cycle");
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 5, 0);
        expect_out(0, K_RD1, 16'h39, "bypass_next_cycle");

        // Scoreboard: mark 3, then clear with a bypassed write.
        drive8(0, 0, 0, 0, 8'h00, 1, 3, 3, 0);
        expect_out(0, K_B1,  16'h0, "mark_not_yet_busy");
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 3, 0);
        expect_out(0, K_B1,  16'h1, "mark_busy1");
        expect_out(0, K_ANY, 16'h1, "mark_any");
        drive8(0, 0, 1, 3, 8'h1E, 0, 0, 3, 0);
        expect_out(0, K_B1,  16'h0, "wb_bypass_busy1");
        expect_out(0, K_RD1, 16'h1E, "wb_bypass_rd1");
        expect_out(0, K_ANY, 16'h1, "wb_any_registered");
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 3, 0);
        expect_out(0, K_B1,  16'h0, "wb_busy_cleared");
        expect_out(0, K_ANY, 16'h0, "wb_any_cleared");
        expect_out(0, K_RD1, 16'h1E, "wb_rd1_held");

        // Same-edge collisions.
        drive8(0, 0, 0, 0, 8'h00, 1, 2, 0, 0);
        drive8(0, 0, 1, 2, 8'h44, 1, 2, 2, 0);
        expect_out(0, K_RD1, 16'h44, "coll_bypass_rd1");
        expect_out(0, K_B1,  16'h0, "coll_bypass_busy1");
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 2, 0);
        expect_out(0, K_RD1, 16'h44, "coll_rd1");
        expect_out(0, K_B1,  16'h1, "coll_new_producer_wins");
        expect_out(0, K_ANY, 16'h1, "coll_any");
        drive8(0, 0, 1, 2, 8'h45, 1, 6, 2, 6);
        expect_out(0, K_RD1, 16'h45, "split_bypass_rd1");
        expect_out(0, K_B2,  16'h0, "split_busy6_not_yet");
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 2, 6);
        expect_out(0, K_B1,  16'h0, "split_busy2_clear");
        expect_out(0, K_B2,  16'h1, "split_busy6_set");
        expect_out(0, K_RD1, 16'h45, "split_rd1");

        // Reset mid-operation drops the same-cycle write and mark.
        drive8(0, 0, 1, 4, 8'h2B, 0, 0, 0, 0);
        drive8(0, 0, 0, 0, 8'h00, 1, 4, 0, 0);
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 4, 0);
        expect_out(0, K_RD1, 16'h2B, "pre_reset_rd4");
        expect_out(0, K_B1,  16'h1, "pre_reset_busy4");
        drive8(0, 1, 1, 4, 8'h99, 1, 1, 4, 1);
        drive8(0, 0, 0, 0, 8'h00, 0, 0, 4, 1);
        expect_out(0, K_RD1, 16'h00, "midreset_rd4");
        expect_out(0, K_B1,  16'h0, "midreset_busy4");
        expect_out(0, K_B2,  16'h0, "midreset_busy1");
        expect_out(0, K_ANY, 16'h0, "midreset_any");

        // BYPASS=0: write visible one cycle later; busy not forwarded.
        drive8(1, 0, 1, 5, 8'h39, 0, 0, 5, 0);
        expect_out(1, K_RD1, 16'h00, "nobyp_write_cycle");
        drive8(1, 0, 0, 0, 8'h00, 1, 5, 5, 0);
        expect_out(1, K_RD1, 16'h39, "nobyp_after_edge");
        drive8(1, 0, 1, 5, 8'h77, 0, 0, 5, 0);
        expect_out(1, K_RD1, 16'h39, "nobyp_old_data");
        expect_out(1, K_B1,  16'h1, "nobyp_busy_held");
        drive8(1, 0, 0, 0, 8'h00, 0, 0, 5, 0);
        expect_out(1, K_RD1, 16'h77, "nobyp_new_data");
        expect_out(1, K_B1,  16'h0, "nobyp_busy_cleared");
        expect_out(1, K_ANY, 16'h0, "nobyp_any");

        // ZERO_REG=1: register 0 ignores writes and marks.
        drive8(2, 0, 1, 0, 8'hFF, 1, 0, 0, 0);
        expect_out(2, K_RD1, 16'h00, "zero_write_cycle_rd");
        expect_out(2, K_B1,  16'h0, "zero_write_cycle_busy");
        drive8(2, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        expect_out(2, K_RD1, 16'h00, "zero_after_rd");
        expect_out(2, K_B1,  16'h0, "zero_after_busy");
        expect_out(2, K_ANY, 16'h0, "zero_any");
        drive8(2, 0, 1, 1, 8'h12, 1, 1, 0, 1);
        expect_out(2, K_RD2, 16'h12, "zero_reg1_bypass");
        drive8(2, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        expect_out(2, K_RD2, 16'h12, "zero_reg1_rd");
        expect_out(2, K_B2,  16'h1, "zero_reg1_busy");
        expect_out(2, K_ANY, 16'h1, "zero_reg1_any");

        // 16x16 configuration: top register and an upper-half address.
        drive16(1, 15, 16'hBEEF, 0, 15);
        expect_out(3, K_RD2, 16'hBEEF, "w16_bypass_rd2");
        expect_out(3, K_RD1, 16'h0000, "w16_rd1_zero");
        drive16(1, 8, 16'h1234, 0, 15);
        expect_out(3, K_RD2, 16'hBEEF, "w16_rd2_held");
        drive16(0, 0, 16'h0000, 8, 15);
        expect_out(3, K_RD1, 16'h1234, "w16_rd1_reg8");
        expect_out(3, K_B2,  16'h0, "w16_busy2");

        // Let the monitor drain; a non-empty queue is a lost comparison.
        @(posedge clk); #1;
        idle_all(1'b0);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
